// File: rtl/stream_pkg.sv
// Shared constants and helpers for the pixel stream engine.
// State encodings, latency ceiling and pixel width helper.
package stream_pkg;

  localparam int MAX_LATENCY = 15;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_RUN    = 2'd1;
  localparam logic [1:0] S_DRAIN  = 2'd2;
  localparam logic [1:0] S_FINISH = 2'd3;

  function automatic int pix_width(input int bpp);
    return 8 * bpp;
  endfunction

endpackage

// File: rtl/stream_delay.sv
// Enable-gated shift register of (valid, address) pairs.
// Stage 0 marks the pixel cycle; the last stage drives write-back.
module stream_delay #(
  parameter int DEPTH = 2,
  parameter int AW    = 20
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          en,
  input  logic          in_valid,
  input  logic [AW-1:0] in_addr,
  output logic          first_valid,
  output logic          out_valid,
  output logic          any_valid,
  output logic [AW-1:0] out_addr
);

  logic [DEPTH-1:0] v;
  logic [AW-1:0]    a [DEPTH];

  // advance one stage per enabled cycle, freeze otherwise
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v <= '0;
      for (int i = 0; i < DEPTH; i++) a[i] <= '0;
    end else if (en) begin
      v[0] <= in_valid;
      a[0] <= in_addr;
      for (int i = 1; i < DEPTH; i++) begin
        v[i] <= v[i-1];
        a[i] <= a[i-1];
      end
    end
  end

  assign first_valid = v[0];
  assign out_valid   = v[DEPTH-1];
  assign out_addr    = a[DEPTH-1];
  assign any_valid   = |v;

endmodule

// File: rtl/pixel_stream_engine.sv
// Frame streamer: reads pixels, aligns x/y/syncs, writes results back.
// Address advances by accumulation only; stalls freeze everything.
module pixel_stream_engine
  import stream_pkg::*;
#(
  parameter int BYTES_PER_PIXEL = 3,
  parameter int LOC_SIZE        = 16,
  parameter int ADDR_WIDTH      = 20,
  parameter int LATENCY         = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         en,
  input  logic                         start,
  input  logic                         continuous,
  input  logic                         stop,
  input  logic [LOC_SIZE-1:0]          width,
  input  logic [LOC_SIZE-1:0]          height,
  input  logic [1:0]                   padding,
  output logic                         rd_en,
  output logic [ADDR_WIDTH-1:0]        rd_addr,
  input  logic [8*BYTES_PER_PIXEL-1:0] rd_data,
  output logic [8*BYTES_PER_PIXEL-1:0] pix,
  output logic                         pix_valid,
  output logic [LOC_SIZE-1:0]          x,
  output logic [LOC_SIZE-1:0]          y,
  output logic                         hsync,
  output logic                         vsync,
  input  logic [8*BYTES_PER_PIXEL-1:0] result,
  output logic                         wr_en,
  output logic [ADDR_WIDTH-1:0]        wr_addr,
  output logic [8*BYTES_PER_PIXEL-1:0] wr_data,
  output logic                         busy,
  output logic                         done,
  output logic [LOC_SIZE-1:0]          frame
);

  localparam int PW = pix_width(BYTES_PER_PIXEL);
  localparam int AW = ADDR_WIDTH;
  localparam int LW = LOC_SIZE;
  localparam int LAT_C =
    (LATENCY > MAX_LATENCY) ? MAX_LATENCY : LATENCY;
  localparam int DEPTH = LAT_C + 1;

  logic [1:0]    state;
  logic          cont_q;
  logic [LW-1:0] w_q, h_q;
  logic [1:0]    pad_q;
  logic [AW-1:0] addr;
  logic [LW-1:0] x_cnt, y_cnt;
  logic [LW-1:0] x_q, y_q;
  logic          hs_q, vs_q;
  logic          fresh_q;
  logic [PW-1:0] hold_q;
  logic          v0, dv, dany;
  logic [AW-1:0] daddr;
  logic          row_end, last_px, zero_dim;
  logic [AW-1:0] step;

  assign zero_dim = (width == '0) || (height == '0);
  assign row_end  = (x_cnt == w_q - LW'(1));
  assign last_px  = row_end && (y_cnt == h_q - LW'(1));
  assign step     = AW'(BYTES_PER_PIXEL)
                  + (row_end ? AW'(pad_q) : '0);

  assign rd_en   = (state == S_RUN) && en;
  assign rd_addr = addr;
  assign busy    = (state != S_IDLE);
  assign done    = (state == S_FINISH) && en;

  // frame control, configuration latch and scan counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      cont_q <= 1'b0;
      w_q    <= '0;
      h_q    <= '0;
      pad_q  <= '0;
      addr   <= '0;
      x_cnt  <= '0;
      y_cnt  <= '0;
      frame  <= '0;
    end else begin
      if (stop) cont_q <= 1'b0;
      if (en) begin
        unique case (state)
          S_IDLE: begin
            if (start) begin
              cont_q <= continuous & ~stop & ~zero_dim;
              addr   <= '0;
              x_cnt  <= '0;
              y_cnt  <= '0;
              if (zero_dim) begin
                state <= S_FINISH;
              end else begin
                w_q   <= width;
                h_q   <= height;
                pad_q <= padding;
                state <= S_RUN;
              end
            end
          end
          S_RUN: begin
            addr <= addr + step;
            if (row_end) begin
              x_cnt <= '0;
              if (last_px) state <= S_DRAIN;
              else y_cnt <= y_cnt + LW'(1);
            end else begin
              x_cnt <= x_cnt + LW'(1);
            end
          end
          S_DRAIN: begin
            if (!dany) state <= S_FINISH;
          end
          S_FINISH: begin
            frame <= frame + LW'(1);
            addr  <= '0;
            x_cnt <= '0;
            y_cnt <= '0;
            state <= (cont_q & ~stop) ? S_RUN : S_IDLE;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // pixel-side alignment; hold read data across a stall
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fresh_q <= 1'b0;
      hold_q  <= '0;
      x_q     <= '0;
      y_q     <= '0;
      hs_q    <= 1'b0;
      vs_q    <= 1'b0;
    end else begin
      fresh_q <= rd_en;
      if (fresh_q) hold_q <= rd_data;
      if (rd_en) begin
        x_q  <= x_cnt;
        y_q  <= y_cnt;
        hs_q <= (x_cnt == '0);
        vs_q <= (x_cnt == '0) && (y_cnt == '0);
      end
    end
  end

  stream_delay #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_delay (
    .clk         (clk),
    .reset_n     (reset_n),
    .en          (en),
    .in_valid    (rd_en),
    .in_addr     (addr),
    .first_valid (v0),
    .out_valid   (dv),
    .any_valid   (dany),
    .out_addr    (daddr)
  );

  assign pix       = fresh_q ? rd_data : hold_q;
  assign pix_valid = v0 && en;
  assign x         = x_q;
  assign y         = y_q;
  assign hsync     = hs_q && pix_valid;
  assign vsync     = vs_q && pix_valid;
  assign wr_en     = dv && en;
  assign wr_addr   = daddr;
  assign wr_data   = wr_en ? result : '0;

endmodule

// File: tb/tb_pixel_stream_engine.sv
// Scoreboard bench for pixel_stream_engine.
// Main DUT LATENCY=1; two echo DUTs at LATENCY 0 and 4.
module tb_pixel_stream_engine;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        en, start, continuous, stop;
  logic [15:0] width, height;
  logic [1:0]  padding;
  logic        rd_en, pix_valid, hsync, vsync;
  logic        wr_en, busy, done;
  logic [19:0] rd_addr, wr_addr;
  logic [23:0] rd_data, pix, result, wr_data, res_q;
  logic [15:0] x, y, frame;
  logic        e_start;
  logic        e_en = 1'b1;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int exp_frame = 0;

  typedef logic [57:0] px_t;
  typedef logic [43:0] wr_t;
  logic [19:0] q_rd [$];
  px_t         q_px [$];
  wr_t         q_wr [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pixel_stream_engine #(
    .BYTES_PER_PIXEL (3),
    .LOC_SIZE        (16),
    .ADDR_WIDTH      (20),
    .LATENCY         (1)
  ) dut (
    .clk (clk), .reset_n (reset_n), .en (en),
    .start (start), .continuous (continuous),
    .stop (stop), .width (width), .height (height),
    .padding (padding), .rd_en (rd_en),
    .rd_addr (rd_addr), .rd_data (rd_data),
    .pix (pix), .pix_valid (pix_valid), .x (x), .y (y),
    .hsync (hsync), .vsync (vsync), .result (result),
    .wr_en (wr_en), .wr_addr (wr_addr),
    .wr_data (wr_data), .busy (busy), .done (done),
    .frame (frame)
  );

  function automatic logic [23:0] pixel_at(input logic [19:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'd2, b + 8'd1, b};
  endfunction

  function automatic logic [7:0] init_b(input int i);
    return 8'(i) ^ 8'h5A;
  endfunction

  // read-only memory model and inverting one-stage pipeline
  always @(posedge clk) begin
    if (rd_en) rd_data <= pixel_at(rd_addr);
    if (en) res_q <= ~pix;
  end
  assign result = res_q;

  // echo DUTs: result is pix delayed LAT enabled cycles
  for (genvar g = 0; g < 2; g++) begin : g_echo
    localparam int LAT = (g == 0) ? 0 : 4;
    logic        rde, pve, hse, vse, wre, bse, dne;
    logic [19:0] rae, wae;
    logic [23:0] rdd, pixe, rese, wde;
    logic [15:0] xe, ye, fre;
    logic [7:0]  emem [256];
    logic [23:0] pipe [4];
    int          wcnt;
    int          dcount;

    pixel_stream_engine #(
      .BYTES_PER_PIXEL (3),
      .LOC_SIZE        (16),
      .ADDR_WIDTH      (20),
      .LATENCY         (LAT)
    ) u (
      .clk (clk), .reset_n (reset_n), .en (e_en),
      .start (e_start), .continuous (1'b0),
      .stop (1'b0), .width (16'd3), .height (16'd2),
      .padding (2'd1), .rd_en (rde), .rd_addr (rae),
      .rd_data (rdd), .pix (pixe), .pix_valid (pve),
      .x (xe), .y (ye), .hsync (hse), .vsync (vse),
      .result (rese), .wr_en (wre), .wr_addr (wae),
      .wr_data (wde), .busy (bse), .done (dne),
      .frame (fre)
    );

    always @(posedge clk) begin
      if (!reset_n) begin
        for (int i = 0; i < 256; i++) emem[i] <= init_b(i);
        wcnt <= 0;
      end else begin
        if (rde)
          rdd <= {emem[rae[7:0] + 8'd2],
                  emem[rae[7:0] + 8'd1],
                  emem[rae[7:0]]};
        if (wre) begin
          emem[wae[7:0]]        <= wde[7:0];
          emem[wae[7:0] + 8'd1] <= wde[15:8];
          emem[wae[7:0] + 8'd2] <= wde[23:16];
          wcnt <= wcnt + 1;
        end
      end
      if (e_en) begin
        pipe[0] <= pixe;
        for (int i = 1; i < 4; i++) pipe[i] <= pipe[i-1];
      end
    end

    if (LAT == 0) begin : g_l0
      assign rese = pixe;
    end else begin : g_ln
      assign rese = pipe[LAT-1];
    end

    always_comb begin
      dcount = 0;
      for (int i = 0; i < 256; i++)
        if (emem[i] !== init_b(i)) dcount++;
    end
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic bad(input string nm, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s actual=%h required=none", nm, act);
  endtask

  // monitor: pop and compare whenever the DUT presents something
  always @(negedge clk) begin
    if (reset_n) begin
      if (rd_en) begin
        if (q_rd.size() == 0) bad("rd_unexpected", 64'(rd_addr));
        else chk("rd_addr", 64'(rd_addr), 64'(q_rd.pop_front()));
      end
      if (pix_valid) begin
        if (q_px.size() == 0) bad("pix_unexpected", 64'(pix));
        else chk("pix_xy_sync", 64'({hsync, vsync, pix, x, y}),
                 64'(q_px.pop_front()));
      end
      if (wr_en) begin
        if (q_wr.size() == 0) bad("wr_unexpected", 64'(wr_addr));
        else chk("wr_addr_data", 64'({wr_addr, wr_data}),
                 64'(q_wr.pop_front()));
      end
      if (!en)
        chk("stall_quiet", 64'({rd_en, pix_valid, wr_en}), 64'(0));
      if (done) begin
        done_cnt = done_cnt + 1;
        done_cyc = cyc;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic push_frame(input int w, input int h, input int pad);
    logic [19:0] a;
    a = '0;
    for (int yy = 0; yy < h; yy++) begin
      for (int xx = 0; xx < w; xx++) begin
        q_rd.push_back(a);
        q_px.push_back({xx == 0, (xx == 0) && (yy == 0),
                        pixel_at(a), 16'(xx), 16'(yy)});
        q_wr.push_back({a, ~pixel_at(a)});
        a = a + 20'd3 + ((xx == w - 1) ? 20'(pad) : 20'd0);
      end
    end
  endtask

  task automatic run_frame(input int w, input int h, input int pad,
                           input int stall_at, input int exp_done);
    int t0, dc0;
    bit got;
    step();
    width = 16'(w);
    height = 16'(h);
    padding = 2'(pad);
    continuous = 1'b0;
    start = 1'b1;
    t0 = cyc;
    dc0 = done_cnt;
    got = 1'b0;
    for (int i = 1; i < 300 && !got; i++) begin
      step();
      start = 1'b0;
      en = !(stall_at != 0 && i >= stall_at && i < stall_at + 5);
      if (done_cnt != dc0) got = 1'b1;
    end
    en = 1'b1;
    if (!got) bad("done_timeout", 64'(cyc - t0));
    else chk("done_cycle", 64'(done_cyc - t0), 64'(exp_done));
    exp_frame++;
    repeat (3) step();
    chk("frame_count", 64'(frame), 64'(exp_frame));
    chk("busy_idle", 64'(busy), 64'(0));
    chk("queues_empty",
        64'(q_rd.size() + q_px.size() + q_wr.size()), 64'(0));
  endtask

  logic any_out;
  assign any_out = |{busy, rd_en, pix_valid, wr_en, done, hsync,
                     vsync, frame, x, y, rd_addr, wr_addr, pix,
                     wr_data};

  initial begin
    #300000;
    $display("FAIL watchdog cycles=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, dc0;
    reset_n = 1'b0;
    en = 1'b1;
    start = 1'b0;
    continuous = 1'b0;
    stop = 1'b0;
    width = '0;
    height = '0;
    padding = '0;
    e_start = 1'b0;
    repeat (3) step();
    chk("reset_outputs", 64'(any_out), 64'(0));
    reset_n = 1'b1;
    step();
    chk("idle_outputs", 64'(any_out), 64'(0));

    push_frame(4, 2, 0);
    run_frame(4, 2, 0, 0, 12);

    push_frame(3, 2, 3);
    run_frame(3, 2, 3, 0, 10);

    push_frame(4, 2, 0);
    run_frame(4, 2, 0, 3, 17);

    run_frame(4, 0, 0, 0, 1);

    step();
    e_start = 1'b1;
    step();
    e_start = 1'b0;
    repeat (30) step();
    chk("echo_l0_writes", 64'(g_echo[0].wcnt), 64'(6));
    chk("echo_l0_mem", 64'(g_echo[0].dcount), 64'(0));
    chk("echo_l4_writes", 64'(g_echo[1].wcnt), 64'(6));
    chk("echo_l4_mem", 64'(g_echo[1].dcount), 64'(0));

    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    exp_frame = 0;
    push_frame(2, 2, 0);
    push_frame(2, 2, 0);
    step();
    width = 16'd2;
    height = 16'd2;
    padding = 2'd0;
    continuous = 1'b1;
    start = 1'b1;
    t0 = cyc;
    dc0 = done_cnt;
    for (int i = 1; i < 100; i++) begin
      step();
      start = 1'b0;
      continuous = 1'b0;
      stop = (i == 10);
      if (i > 12 && !busy) break;
    end
    stop = 1'b0;
    chk("cont_done_pulses", 64'(done_cnt - dc0), 64'(2));
    chk("cont_last_done", 64'(done_cyc - t0), 64'(16));
    chk("cont_frame", 64'(frame), 64'(2));
    chk("cont_idle", 64'(busy), 64'(0));
    chk("cont_queues",
        64'(q_rd.size() + q_px.size() + q_wr.size()), 64'(0));

    push_frame(4, 2, 0);
    step();
    width = 16'd4;
    height = 16'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (4) step();
    reset_n = 1'b0;
    #1;
    chk("reset_mid_outputs", 64'(any_out), 64'(0));
    q_rd.delete();
    q_px.delete();
    q_wr.delete();
    repeat (2) step();
    reset_n = 1'b1;
    repeat (10) step();
    chk("after_reset_idle", 64'(busy), 64'(0));
    chk("after_reset_frame", 64'(frame), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
